// File: rtl/conv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : conv_pkg
// Brief  : Shared constants, sequencer state encoding and padding helpers.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
package conv_pkg;

    localparam int c_pix_w    = 8;
    localparam int c_knl_taps = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } seq_state_t;

    // Zero padding adds one row/column on each side of the image.
    function automatic int pad_dim(input int dim);
        return dim + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_2d_seq_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : conv_2d_seq_if
// Brief  : Control, kernel-write, frame-buffer and conv_2d signals of the sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
interface conv_2d_seq_if import conv_pkg::*; #(
    parameter int PIX_W  = c_pix_w,
    parameter int ADDR_W = 6
);
    logic              i_start;
    logic              i_knl_we;
    logic [3:0]        i_knl_addr;
    logic [PIX_W-1:0]  i_knl_data;
    logic [ADDR_W-1:0] o_rd_addr0;
    logic [ADDR_W-1:0] o_rd_addr1;
    logic [ADDR_W-1:0] o_rd_addr2;
    logic [PIX_W-1:0]  i_rd_data0;
    logic [PIX_W-1:0]  i_rd_data1;
    logic [PIX_W-1:0]  i_rd_data2;
    logic              o_load_knl;
    logic              o_en_conv;
    logic [PIX_W-1:0]  o_data1;
    logic [PIX_W-1:0]  o_data2;
    logic [PIX_W-1:0]  o_data3;
    logic              o_pix_valid;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_knl_we, i_knl_addr, i_knl_data,
        input  i_rd_data0, i_rd_data1, i_rd_data2,
        output o_rd_addr0, o_rd_addr1, o_rd_addr2,
        output o_load_knl, o_en_conv, o_data1, o_data2, o_data3,
        output o_pix_valid, o_busy, o_done
    );

    modport slave (
        output i_start, i_knl_we, i_knl_addr, i_knl_data,
        output i_rd_data0, i_rd_data1, i_rd_data2,
        input  o_rd_addr0, o_rd_addr1, o_rd_addr2,
        input  o_load_knl, o_en_conv, o_data1, o_data2, o_data3,
        input  o_pix_valid, o_busy, o_done
    );
endinterface
`default_nettype wire

// File: rtl/conv_2d_addr_gen.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : conv_2d_addr_gen
// Brief  : Strip/column walker issuing three row addresses per window column.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module conv_2d_addr_gen import conv_pkg::*; #(
    parameter int IMG_H  = 1,
    parameter int IMG_W  = 10,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_init,
    output logic [ADDR_W-1:0] o_addr0,
    output logic [ADDR_W-1:0] o_addr1,
    output logic [ADDR_W-1:0] o_addr2,
    output logic              o_col_tag
);
    localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_w2         = ADDR_W'(pad_dim(IMG_W));
    localparam logic [ADDR_W-1:0] c_w2x2       = ADDR_W'(2 * pad_dim(IMG_W));
    localparam logic [ADDR_W-1:0] c_last_col   = ADDR_W'(pad_dim(IMG_W) - 1);
    localparam logic [ADDR_W-1:0] c_last_strip = ADDR_W'(IMG_H - 1);

    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_strip;
    logic [ADDR_W-1:0] r_base0;
    logic [ADDR_W-1:0] r_base1;
    logic [ADDR_W-1:0] r_base2;
    logic              r_active;

    // o_col_tag always describes the column currently on the address outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_strip   <= '0;
            r_base0   <= '0;
            r_base1   <= '0;
            r_base2   <= '0;
            r_active  <= 1'b0;
            o_addr0   <= '0;
            o_addr1   <= '0;
            o_addr2   <= '0;
            o_col_tag <= 1'b0;
        end else if (i_init) begin
            r_col     <= '0;
            r_strip   <= '0;
            r_base0   <= '0;
            r_base1   <= c_w2;
            r_base2   <= c_w2x2;
            r_active  <= 1'b1;
            o_addr0   <= '0;
            o_addr1   <= c_w2;
            o_addr2   <= c_w2x2;
            o_col_tag <= 1'b0;
        end else if (r_active) begin
            if (r_col == c_last_col) begin
                o_col_tag <= 1'b0;
                if (r_strip == c_last_strip) begin
                    r_active <= 1'b0;
                end else begin
                    r_col   <= '0;
                    r_strip <= r_strip + c_one;
                    r_base0 <= r_base0 + c_w2;
                    r_base1 <= r_base1 + c_w2;
                    r_base2 <= r_base2 + c_w2;
                    o_addr0 <= r_base0 + c_w2;
                    o_addr1 <= r_base1 + c_w2;
                    o_addr2 <= r_base2 + c_w2;
                end
            end else begin
                r_col     <= r_col + c_one;
                o_addr0   <= o_addr0 + c_one;
                o_addr1   <= o_addr1 + c_one;
                o_addr2   <= o_addr2 + c_one;
                o_col_tag <= (r_col != '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/conv_2d_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : conv_2d_seq
// Brief  : Kernel loader and padded-frame streamer feeding the conv_2d datapath.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module conv_2d_seq import conv_pkg::*; #(
    parameter int IMG_H    = 1,
    parameter int IMG_W    = 10,
    parameter int PIX_W    = c_pix_w,
    parameter int ADDR_W   = 6,
    parameter int CONV_LAT = 1
) (
    input logic           clk,
    input logic           i_rst,
    conv_2d_seq_if.master bus
);
    localparam int                 c_cnt_w       = 16;
    localparam int                 c_vld_dly     = CONV_LAT + 2;
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_last_load   = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0] c_last_stream = c_cnt_w'(IMG_H * pad_dim(IMG_W) - 1);
    localparam logic [c_cnt_w-1:0] c_last_drain  = c_cnt_w'((CONV_LAT > 0) ? CONV_LAT - 1 : 0);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [PIX_W-1:0]     r_knl [c_knl_taps];
    logic [PIX_W-1:0]     w_knl [c_knl_taps];
    logic                 w_knl_wr;
    logic                 w_load_nxt;
    logic                 w_en_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic [PIX_W-1:0]     w_d1_nxt;
    logic [PIX_W-1:0]     w_d2_nxt;
    logic [PIX_W-1:0]     w_d3_nxt;
    logic                 w_addr_init;
    logic                 w_col_tag;
    logic [c_vld_dly-1:0] r_vld_pipe;

    assign w_knl_wr = (r_state == ST_IDLE) && bus.i_knl_we && (bus.i_knl_addr <= 4'd8);

    // Write-merged view lets a tap written alongside i_start reach the first load column.
    always_comb begin
        for (int i = 0; i < c_knl_taps; i++) begin
            w_knl[i] = (w_knl_wr && (bus.i_knl_addr == 4'(i))) ? bus.i_knl_data : r_knl[i];
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < c_knl_taps; i++) begin
                r_knl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < c_knl_taps; i++) begin
                r_knl[i] <= w_knl[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load_nxt  = 1'b0;
        w_en_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_d1_nxt    = '0;
        w_d2_nxt    = '0;
        w_d3_nxt    = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_load_nxt  = 1'b1;
                    w_d1_nxt    = w_knl[0];
                    w_d2_nxt    = w_knl[3];
                    w_d3_nxt    = w_knl[6];
                end
            end
            ST_LOAD: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == c_last_load) begin
                    w_state_nxt = ST_STREAM;
                    w_cnt_nxt   = '0;
                    w_en_nxt    = 1'b1;
                    w_d1_nxt    = bus.i_rd_data0;
                    w_d2_nxt    = bus.i_rd_data1;
                    w_d3_nxt    = bus.i_rd_data2;
                end else begin
                    w_cnt_nxt  = r_cnt + c_cnt_one;
                    w_load_nxt = 1'b1;
                    w_d1_nxt   = (r_cnt == '0) ? r_knl[1] : r_knl[2];
                    w_d2_nxt   = (r_cnt == '0) ? r_knl[4] : r_knl[5];
                    w_d3_nxt   = (r_cnt == '0) ? r_knl[7] : r_knl[8];
                end
            end
            ST_STREAM: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == c_last_stream) begin
                    w_cnt_nxt = '0;
                    if (CONV_LAT == 0) begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DRAIN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                    w_en_nxt  = 1'b1;
                    w_d1_nxt  = bus.i_rd_data0;
                    w_d2_nxt  = bus.i_rd_data1;
                    w_d3_nxt  = bus.i_rd_data2;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_last_drain) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + c_cnt_one;
                    w_busy_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            bus.o_load_knl <= 1'b0;
            bus.o_en_conv  <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_data1    <= '0;
            bus.o_data2    <= '0;
            bus.o_data3    <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            bus.o_load_knl <= w_load_nxt;
            bus.o_en_conv  <= w_en_nxt;
            bus.o_busy     <= w_busy_nxt;
            bus.o_done     <= w_done_nxt;
            bus.o_data1    <= w_d1_nxt;
            bus.o_data2    <= w_d2_nxt;
            bus.o_data3    <= w_d3_nxt;
        end
    end

    // Addresses lead o_data by two cycles; the first column is issued in the second load cycle.
    assign w_addr_init = (r_state == ST_LOAD) && (r_cnt == '0);

    conv_2d_addr_gen #(
        .IMG_H  (IMG_H),
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (i_rst),
        .i_init    (w_addr_init),
        .o_addr0   (bus.o_rd_addr0),
        .o_addr1   (bus.o_rd_addr1),
        .o_addr2   (bus.o_rd_addr2),
        .o_col_tag (w_col_tag)
    );

    // Tag travels through buffer read, o_data register and conv_2d latency.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[c_vld_dly-2:0], w_col_tag};
        end
    end

    assign bus.o_pix_valid = r_vld_pipe[c_vld_dly-1];

endmodule
`default_nettype wire

// File: tb/tb_conv_2d_seq.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_conv_2d_seq
// Brief  : Directed checks of conv_2d_seq on a 1x10 and a 3x4 image.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_conv_2d_seq;
    import conv_pkg::*;

    localparam int PIX_W    = 8;
    localparam int ADDR_W   = 6;
    localparam int CONV_LAT = 1;

    typedef struct packed {
        logic       load;
        logic       en;
        logic       valid;
        logic       busy;
        logic       done;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        logic       chk_addr;
        logic [5:0] a0;
        logic [5:0] a1;
        logic [5:0] a2;
    } vec_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] kexp [9];
    vec_t       tbl  [24];
    wr_t        wr_tbl [11];

    always #5 clk = ~clk;

    conv_2d_seq_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus_a ();
    conv_2d_seq_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus_b ();

    conv_2d_seq #(
        .IMG_H(1), .IMG_W(10), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .CONV_LAT(CONV_LAT)
    ) dut_a (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus_a.master)
    );

    conv_2d_seq #(
        .IMG_H(3), .IMG_W(4), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .CONV_LAT(CONV_LAT)
    ) dut_b (
        .clk   (clk),
        .i_rst (rst),
        .bus   (bus_b.master)
    );

    // Frame buffers: word at address a holds a.
    always @(posedge clk) begin
        bus_a.i_rd_data0 <= PIX_W'(bus_a.o_rd_addr0);
        bus_a.i_rd_data1 <= PIX_W'(bus_a.o_rd_addr1);
        bus_a.i_rd_data2 <= PIX_W'(bus_a.o_rd_addr2);
        bus_b.i_rd_data0 <= PIX_W'(bus_b.o_rd_addr0);
        bus_b.i_rd_data1 <= PIX_W'(bus_b.o_rd_addr1);
        bus_b.i_rd_data2 <= PIX_W'(bus_b.o_rd_addr2);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] obs_a();
        return {bus_a.o_load_knl, bus_a.o_en_conv, bus_a.o_pix_valid, bus_a.o_busy,
                bus_a.o_done, bus_a.o_data1, bus_a.o_data2, bus_a.o_data3};
    endfunction

    function automatic logic [28:0] obs_b();
        return {bus_b.o_load_knl, bus_b.o_en_conv, bus_b.o_pix_valid, bus_b.o_busy,
                bus_b.o_done, bus_b.o_data1, bus_b.o_data2, bus_b.o_data3};
    endfunction

    function automatic logic [17:0] addr_a();
        return {bus_a.o_rd_addr0, bus_a.o_rd_addr1, bus_a.o_rd_addr2};
    endfunction

    // Expected trace of one 1x10 frame (N=12, CONV_LAT=1), cycle 0 = start cycle.
    task automatic fill_table();
        vec_t v;
        int   ka;
        for (int c = 0; c < 24; c++) begin
            v      = '0;
            v.busy = (c >= 1 && c <= 16);
            v.load = (c >= 1 && c <= 3);
            if (v.load) begin
                v.d1 = kexp[c-1];
                v.d2 = kexp[c+2];
                v.d3 = kexp[c+5];
            end
            v.en = (c >= 4 && c <= 15);
            if (v.en) begin
                v.d1 = 8'(c - 4);
                v.d2 = 8'(c - 4 + 12);
                v.d3 = 8'(c - 4 + 24);
            end
            v.valid    = (c >= 7 && c <= 16);
            v.done     = (c == 17);
            v.chk_addr = (c >= 2);
            ka         = (c - 2 > 11) ? 11 : c - 2;
            v.a0       = 6'(ka);
            v.a1       = 6'(ka + 12);
            v.a2       = 6'(ka + 24);
            tbl[c]     = v;
        end
    endtask

    // One frame on dut_a; optional tap write with start, optional start+write at inj_cycle.
    task automatic run_a(input int inj_cycle, input int tail, input logic same_we,
                         input logic [3:0] same_addr, input logic [7:0] same_data);
        fill_table();
        for (int c = 0; c < 18 + tail; c++) begin
            bus_a.i_start    = (c == 0) || (c == inj_cycle);
            bus_a.i_knl_we   = (c == 0) ? same_we : (c == inj_cycle);
            bus_a.i_knl_addr = (c == 0) ? same_addr : 4'd4;
            bus_a.i_knl_data = (c == 0) ? same_data : 8'h55;
            check($sformatf("a_c%0d_outs", c), 64'(obs_a()),
                  64'({tbl[c].load, tbl[c].en, tbl[c].valid, tbl[c].busy, tbl[c].done,
                       tbl[c].d1, tbl[c].d2, tbl[c].d3}));
            if (tbl[c].chk_addr) begin
                check($sformatf("a_c%0d_addr", c), 64'(addr_a()),
                      64'({tbl[c].a0, tbl[c].a1, tbl[c].a2}));
            end
            tick();
        end
        bus_a.i_start  = 1'b0;
        bus_a.i_knl_we = 1'b0;
    endtask

    initial begin
        logic seen;
        int   n_en;
        int   n_vld;
        int   kv;
        int   ks;
        logic exp_en;
        logic exp_vld;
        logic exp_busy;
        logic exp_done;
        logic exp_load;
        logic [7:0] e1;
        logic [7:0] e2;
        logic [7:0] e3;

        rst              = 1'b1;
        bus_a.i_start    = 1'b0;
        bus_a.i_knl_we   = 1'b0;
        bus_a.i_knl_addr = 4'd0;
        bus_a.i_knl_data = 8'd0;
        bus_b.i_start    = 1'b0;
        bus_b.i_knl_we   = 1'b0;
        bus_b.i_knl_addr = 4'd0;
        bus_b.i_knl_data = 8'd0;
        tick();
        check("reset_a", 64'({obs_a(), addr_a()}), 64'd0);
        check("reset_b", 64'({obs_b(), bus_b.o_rd_addr0, bus_b.o_rd_addr1, bus_b.o_rd_addr2}), 64'd0);
        rst = 1'b0;
        tick();

        // Taps k_i = i+1, then two out-of-range writes that must not land.
        for (int i = 0; i < 9; i++) begin
            wr_tbl[i] = {4'(i), 8'(i + 1)};
        end
        wr_tbl[9]  = {4'd9, 8'h77};
        wr_tbl[10] = {4'd12, 8'h66};
        for (int i = 0; i < 11; i++) begin
            bus_a.i_knl_we   = 1'b1;
            bus_a.i_knl_addr = wr_tbl[i].addr;
            bus_a.i_knl_data = wr_tbl[i].data;
            tick();
        end
        bus_a.i_knl_we = 1'b0;
        for (int i = 0; i < 9; i++) begin
            kexp[i] = 8'(i + 1);
        end
        run_a(-1, 0, 1'b0, 4'd0, 8'd0);

        // Back-to-back start with a same-cycle k3 write; mid-stream start/write ignored.
        kexp[3] = 8'h21;
        run_a(8, 3, 1'b1, 4'd3, 8'h21);
        run_a(-1, 0, 1'b0, 4'd0, 8'd0);

        // Asynchronous reset in the middle of streaming.
        bus_a.i_start = 1'b1;
        tick();
        bus_a.i_start = 1'b0;
        repeat (7) tick();
        check("a_pre_rst_en", 64'(bus_a.o_en_conv), 64'd1);
        #1 rst = 1'b1;
        #1;
        check("a_rst_outs", 64'({obs_a(), addr_a()}), 64'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus_a.o_done || bus_a.o_busy || bus_a.o_en_conv) seen = 1'b1;
        end
        check("a_post_rst_quiet", 64'(seen), 64'd0);
        for (int i = 0; i < 9; i++) begin
            kexp[i] = 8'd0;
        end
        run_a(-1, 0, 1'b0, 4'd0, 8'd0);

        // Three strips of width 4: N=18, done at cycle 23, valid for columns 2..5 only.
        n_en  = 0;
        n_vld = 0;
        bus_b.i_start = 1'b1;
        for (int c = 0; c < 26; c++) begin
            exp_load = (c >= 1 && c <= 3);
            exp_en   = (c >= 4 && c <= 21);
            exp_busy = (c >= 1 && c <= 22);
            exp_done = (c == 23);
            kv       = c - 5;
            exp_vld  = (kv >= 0) && (kv <= 17) && ((kv % 6) >= 2);
            ks       = c - 4;
            e1       = exp_en ? 8'(ks)      : 8'd0;
            e2       = exp_en ? 8'(ks + 6)  : 8'd0;
            e3       = exp_en ? 8'(ks + 12) : 8'd0;
            check($sformatf("b_c%0d_outs", c), 64'(obs_b()),
                  64'({exp_load, exp_en, exp_vld, exp_busy, exp_done, e1, e2, e3}));
            if (c == 14) begin
                check("b_strip2_col0_addr",
                      64'({bus_b.o_rd_addr0, bus_b.o_rd_addr1, bus_b.o_rd_addr2}),
                      64'({6'd12, 6'd18, 6'd24}));
            end
            if (c == 25) begin
                check("b_addr_hold",
                      64'({bus_b.o_rd_addr0, bus_b.o_rd_addr1, bus_b.o_rd_addr2}),
                      64'({6'd17, 6'd23, 6'd29}));
            end
            if (bus_b.o_en_conv)   n_en++;
            if (bus_b.o_pix_valid) n_vld++;
            tick();
            bus_b.i_start = 1'b0;
        end
        check("b_en_count", 64'(n_en), 64'd18);
        check("b_valid_count", 64'(n_vld), 64'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
